// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared types, constants and helpers for the branch predictor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package branch_predictor_pkg;

  // 2-bit saturating counter states
  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  // Table entries come out of reset as weak-not-taken
  localparam logic [1:0] BP_INIT = CNT_WNT;

  localparam int STAT_W = 16;

  // Move a counter one step toward the actual outcome, saturating at both ends
  function automatic logic [1:0] cnt_train(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != CNT_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != CNT_SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

  // Statistics counters stick at all-ones
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/branch_predictor_fifo.sv
// branch_predictor_fifo: in-order queue of outstanding predictions with flush.
// Latency: an entry pushed in cycle N is visible at the head in cycle N+1; no bypass.
// Backpressure: push refused while full (even with a same-cycle pop); pop ignored while empty; flush wins.
// Ports: push_vld_i/push_dat_i push side, pop_rdy_i/pop_dat_o pop side, flush_i, full_o/empty_o status.
module branch_predictor_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_vld_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_rdy_i,
  output logic [W-1:0] pop_dat_o,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push_fire;
  logic             pop_fire;

  assign full_o    = (occ_q == OCC_W'(DEPTH));
  assign empty_o   = (occ_q == '0);
  assign pop_dat_o = mem_q[rd_ptr_q];

  // Fullness is judged on the current occupancy, so a same-cycle pop never frees a slot
  assign push_fire = push_vld_i & ~full_o & ~flush_i;
  assign pop_fire  = pop_rdy_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(push_fire) - OCC_W'(pop_fire);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter predictor with in-order resolve queue and stats.
// Latency: pred_taken/pred_ready/res_ready combinational; mispredict, correct_taken, counts 1 cycle after pop.
// Backpressure: pred_ready low while DEPTH branches are outstanding; res_ready low when none are.
// Ports: pred_* fetch request, res_* execute outcome, flush, mispredict/correct_taken pulse, branch_cnt/miss_cnt.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 6,
  parameter int DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic [WIDTH-1:0] pred_pc,
  output logic             pred_ready,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic             res_comp,
  output logic             res_ready,
  input  logic             flush,
  output logic             mispredict,
  output logic             correct_taken,
  output logic [15:0]      branch_cnt,
  output logic [15:0]      miss_cnt
);

  localparam int TBL_N = 1 << IDX_BITS;

  logic [1:0]          tbl_q [TBL_N];
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS:0]   head_dat;
  logic [IDX_BITS-1:0] head_idx;
  logic                head_pred;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push_fire;
  logic                pop_fire;
  logic                mispredict_q, mispredict_d;
  logic                correct_taken_q, correct_taken_d;
  logic [15:0]         branch_cnt_q, branch_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;
  logic                unused_pc;

  assign pred_idx   = pred_pc[IDX_BITS+1:2];
  assign unused_pc  = ^{pred_pc[WIDTH-1:IDX_BITS+2], pred_pc[1:0]};
  assign pred_taken = tbl_q[pred_idx][1];
  assign pred_ready = ~fifo_full;
  assign res_ready  = ~fifo_empty;
  assign head_idx   = head_dat[IDX_BITS:1];
  assign head_pred  = head_dat[0];

  assign push_fire  = pred_valid & pred_ready;
  assign pop_fire   = res_valid & res_ready & ~flush;

  branch_predictor_fifo #(
    .DEPTH(DEPTH),
    .W    (IDX_BITS + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_vld_i(push_fire),
    .push_dat_i({pred_idx, pred_taken}),
    .pop_rdy_i (res_valid),
    .pop_dat_o (head_dat),
    .flush_i   (flush),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    mispredict_d    = pop_fire & (head_pred != res_comp);
    correct_taken_d = pop_fire & res_comp;
    branch_cnt_d    = pop_fire ? sat_inc(branch_cnt_q) : branch_cnt_q;
    miss_cnt_d      = mispredict_d ? sat_inc(miss_cnt_q) : miss_cnt_q;
  end

  // Training reads the live table entry; a same-cycle prediction still sees the old value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TBL_N; i++) tbl_q[i] <= BP_INIT;
    end else if (pop_fire) begin
      tbl_q[head_idx] <= cnt_train(tbl_q[head_idx], res_comp);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_q    <= 1'b0;
      correct_taken_q <= 1'b0;
      branch_cnt_q    <= '0;
      miss_cnt_q      <= '0;
    end else begin
      mispredict_q    <= mispredict_d;
      correct_taken_q <= correct_taken_d;
      branch_cnt_q    <= branch_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
    end
  end

  assign mispredict    = mispredict_q;
  assign correct_taken = correct_taken_q;
  assign branch_cnt    = branch_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: randomized and directed stimulus against a queue/array reference model.
module tb_branch_predictor;

  localparam int WIDTH    = 32;
  localparam int IDX_BITS = 6;
  localparam int DEPTH    = 4;
  localparam int TBL_N    = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_ready;
  logic        pred_taken;
  logic        res_valid;
  logic        res_comp;
  logic        res_ready;
  logic        flush;
  logic        mispredict;
  logic        correct_taken;
  logic [15:0] branch_cnt;
  logic [15:0] miss_cnt;

  always #5 clk = ~clk;

  branch_predictor #(
    .WIDTH   (WIDTH),
    .IDX_BITS(IDX_BITS),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pred_valid   (pred_valid),
    .pred_pc      (pred_pc),
    .pred_ready   (pred_ready),
    .pred_taken   (pred_taken),
    .res_valid    (res_valid),
    .res_comp     (res_comp),
    .res_ready    (res_ready),
    .flush        (flush),
    .mispredict   (mispredict),
    .correct_taken(correct_taken),
    .branch_cnt   (branch_cnt),
    .miss_cnt     (miss_cnt)
  );

  // Reference model: counter values as integers 0..3, in-flight branches as a queue
  typedef struct {
    int idx;
    bit pred;
  } ent_t;

  int   tbl [TBL_N];
  ent_t q[$];
  int   m_br;
  int   m_miss;
  bit   m_mis;
  bit   m_ct;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return (pc / 4) % TBL_N;
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    return tbl[idx_of(pc)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TBL_N; i++) tbl[i] = 1;
    q.delete();
    m_br   = 0;
    m_miss = 0;
    m_mis  = 0;
    m_ct   = 0;
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model, check registered outputs
  task automatic step(input bit pv, input logic [31:0] pc, input bit rv, input bit rc, input bit fl);
    bit   ptk;
    bit   do_push;
    bit   do_pop;
    ent_t h;
    @(negedge clk);
    pred_valid = pv;
    pred_pc    = pc;
    res_valid  = rv;
    res_comp   = rc;
    flush      = fl;
    #1;
    check_val("pred_taken", pred_taken, model_pred(pc));
    check_val("pred_ready", pred_ready, q.size() < DEPTH);
    check_val("res_ready", res_ready, q.size() != 0);
    ptk     = model_pred(pc);
    do_push = pv && (q.size() < DEPTH);
    do_pop  = rv && (q.size() > 0);
    if (fl) begin
      q.delete();
      m_mis = 0;
      m_ct  = 0;
    end else begin
      if (do_pop) begin
        h     = q.pop_front();
        m_mis = (h.pred != rc);
        m_ct  = rc;
        if (rc) tbl[h.idx] = (tbl[h.idx] < 3) ? tbl[h.idx] + 1 : 3;
        else    tbl[h.idx] = (tbl[h.idx] > 0) ? tbl[h.idx] - 1 : 0;
        if (m_br < 65535) m_br++;
        if (m_mis && m_miss < 65535) m_miss++;
      end else begin
        m_mis = 0;
        m_ct  = 0;
      end
      if (do_push) q.push_back('{idx_of(pc), ptk});
    end
    @(posedge clk);
    #1;
    check_val("mispredict", mispredict, m_mis);
    check_val("correct_taken", correct_taken, m_ct);
    check_val("branch_cnt", branch_cnt, m_br);
    check_val("miss_cnt", miss_cnt, m_miss);
  endtask

  initial begin
    logic [31:0] pc;
    reset      = 1'b1;
    pred_valid = 1'b0;
    pred_pc    = 32'h100;
    res_valid  = 1'b0;
    res_comp   = 1'b0;
    flush      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state
    check_val("rst_pred_taken", pred_taken, 1'b0);
    check_val("rst_pred_ready", pred_ready, 1'b1);
    check_val("rst_res_ready", res_ready, 1'b0);
    check_val("rst_branch_cnt", branch_cnt, 16'd0);
    check_val("rst_miss_cnt", miss_cnt, 16'd0);
    check_val("rst_mispredict", mispredict, 1'b0);

    // Predict 0x100 (NT), resolve taken -> mispredict, entry moves to weak-T
    step(1, 32'h100, 0, 0, 0);
    step(0, 32'h100, 1, 1, 0);
    check_val("t2_mispredict", mispredict, 1'b1);
    check_val("t2_correct_taken", correct_taken, 1'b1);
    check_val("t2_miss_cnt", miss_cnt, 16'd1);
    pred_pc = 32'h100;
    #1;
    check_val("t2_pred_after_train", pred_taken, 1'b1);

    // Train 0x200 taken four times -> strong-T; one NT leaves weak-T
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h200, 0, 0, 0);
      step(0, 32'h200, 1, 1, 0);
    end
    step(1, 32'h200, 0, 0, 0);
    step(0, 32'h200, 1, 0, 0);
    pred_pc = 32'h200;
    #1;
    check_val("t3_pred_weak_t", pred_taken, 1'b1);

    // Fill the queue, refuse a 5th push, refuse push alongside a pop
    for (int i = 0; i < DEPTH; i++) step(1, 32'h300 + 32'(i * 4), 0, 0, 0);
    check_val("t4_full_ready", pred_ready, 1'b0);
    step(1, 32'h340, 0, 0, 0);
    step(1, 32'h344, 1, 1, 0);
    check_val("t4_ready_after_pop", pred_ready, 1'b1);
    check_val("t4_occupancy3", 32'(q.size()), 32'd3);

    // Flush with res_valid on a 3-entry queue
    step(0, 32'h0, 1, 1, 1);
    check_val("t5_flush_res_ready", res_ready, 1'b0);
    check_val("t5_flush_mispredict", mispredict, 1'b0);

    // Random traffic with colliding indices and varying upper PC bits
    for (int i = 0; i < 3000; i++) begin
      pc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      step(($urandom % 4) != 0, pc, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           ($urandom % 32) == 0);
    end

    // Saturate both counters with back-to-back mispredictions
    step(0, 32'h0, 0, 0, 1);
    step(1, 32'h400, 0, 0, 0);
    for (int i = 0; i < 65540; i++) begin
      step(1, 32'h400 + 32'((i % 3) * 4), 1, !q[0].pred, 0);
    end
    check_val("sat_branch_cnt", branch_cnt, 16'hFFFF);
    check_val("sat_miss_cnt", miss_cnt, 16'hFFFF);

    // Train 0x200 toward taken, then reset mid-cycle without a clock edge
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h200, 0, 0, 0);
      step(0, 32'h200, 1, 1, 0);
    end
    step(1, 32'h200, 1, 1, 0);
    step(1, 32'h200, 0, 0, 0);
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    pred_pc    = 32'h200;
    #2;
    check_val("pre_rst_pred_taken", pred_taken, 1'b1);
    reset = 1'b1;
    #1;
    check_val("arst_pred_taken", pred_taken, 1'b0);
    check_val("arst_pred_ready", pred_ready, 1'b1);
    check_val("arst_res_ready", res_ready, 1'b0);
    check_val("arst_mispredict", mispredict, 1'b0);
    check_val("arst_correct_taken", correct_taken, 1'b0);
    check_val("arst_branch_cnt", branch_cnt, 16'd0);
    check_val("arst_miss_cnt", miss_cnt, 16'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Short run after reset to confirm normal operation resumes
    for (int i = 0; i < 50; i++) begin
      pc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 3)) << 2);
      step($urandom_range(0, 1) == 1, pc, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
